// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch/execute signal bundle for the branch target predictor
interface branch_target_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] pc_IF;
  logic [WORD_SIZE-1:0] branch_predicted_pc_IF;
  logic                 predict_taken_IF;
  logic                 valid_EX;
  logic                 stall_EX;
  logic                 is_branch_EX;
  logic [WORD_SIZE-1:0] pc_EX;
  logic [WORD_SIZE-1:0] branch_predicted_pc_EX;
  logic                 actual_taken_EX;
  logic [WORD_SIZE-1:0] actual_target_EX;
  logic                 mispredict_flush;
  logic [WORD_SIZE-1:0] correct_pc;
  logic [15:0]          branch_count;
  logic [15:0]          mispredict_count;

  modport master (
    output pc_IF, valid_EX, stall_EX, is_branch_EX, pc_EX,
           branch_predicted_pc_EX, actual_taken_EX, actual_target_EX,
    input  branch_predicted_pc_IF, predict_taken_IF, mispredict_flush,
           correct_pc, branch_count, mispredict_count
  );

  modport slave (
    input  pc_IF, valid_EX, stall_EX, is_branch_EX, pc_EX,
           branch_predicted_pc_EX, actual_taken_EX, actual_target_EX,
    output branch_predicted_pc_IF, predict_taken_IF, mispredict_flush,
           correct_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters, EX resolution and flush
module branch_target_predictor #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  branch_target_predictor_if.slave bus
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

  // Flat register array so IF reads are asynchronous and see pre-update contents.
  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [15:0]          branch_count_q, branch_count_d;
  logic [15:0]          mispredict_count_q, mispredict_count_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  if_hit, ex_hit, resolve, flush;
  logic [WORD_SIZE-1:0]  correct_pc;

  assign if_idx = bus.pc_IF[INDEX_BITS-1:0];
  assign if_tag = bus.pc_IF[WORD_SIZE-1:INDEX_BITS];
  assign ex_idx = bus.pc_EX[INDEX_BITS-1:0];
  assign ex_tag = bus.pc_EX[WORD_SIZE-1:INDEX_BITS];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign bus.predict_taken_IF       = if_hit && ctr_q[if_idx][1];
  assign bus.branch_predicted_pc_IF = bus.predict_taken_IF ? target_q[if_idx]
                                                           : bus.pc_IF + WORD_SIZE'(1);

  assign resolve    = bus.valid_EX && !bus.stall_EX && reset_n;
  assign correct_pc = (bus.is_branch_EX && bus.actual_taken_EX) ? bus.actual_target_EX
                                                                : bus.pc_EX + WORD_SIZE'(1);
  assign flush      = resolve && (correct_pc != bus.branch_predicted_pc_EX);

  assign bus.correct_pc       = correct_pc;
  assign bus.mispredict_flush = flush;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && bus.is_branch_EX && (branch_count_q != 16'hFFFF))
      branch_count_d = branch_count_q + 16'd1;
    if (flush && (mispredict_count_q != 16'hFFFF))
      mispredict_count_d = mispredict_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < ENTRIES; k++) begin
        tag_q[k]    <= '0;
        target_q[k] <= '0;
        ctr_q[k]    <= 2'b01;
      end
    end else if (resolve) begin
      if (bus.is_branch_EX) begin
        if (bus.actual_taken_EX) begin
          target_q[ex_idx] <= bus.actual_target_EX;
          if (ex_hit) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
          end else begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            ctr_q[ex_idx]   <= 2'b10;
          end
        end else if (ex_hit && (ctr_q[ex_idx] != 2'b00)) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_hit) begin
        // A non-branch hitting the BTB means the entry is aliased or stale.
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - randomized and directed checks against a behavioural BTB model
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_target_predictor_if bus ();
  branch_target_predictor dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model: table of entries plus two saturating tallies.
  int m_valid [16];
  int m_tag   [16];
  int m_target[16];
  int m_ctr   [16];
  int m_bcnt, m_mcnt;

  function automatic void m_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  function automatic int m_taken(int pc);
    int idx = pc % 16;
    return (m_valid[idx] != 0 && m_tag[idx] == pc / 16 && m_ctr[idx] >= 2) ? 1 : 0;
  endfunction

  function automatic int m_pred(int pc);
    return (m_taken(pc) != 0) ? m_target[pc % 16] : (pc + 1) % 65536;
  endfunction

  task automatic set_ex(input bit v, input bit s, input bit br, input int pc, input int pred,
                        input bit tk, input int tgt);
    bus.valid_EX               = v;
    bus.stall_EX               = s;
    bus.is_branch_EX           = br;
    bus.pc_EX                  = 16'(pc);
    bus.branch_predicted_pc_EX = 16'(pred);
    bus.actual_taken_EX        = tk;
    bus.actual_target_EX       = 16'(tgt);
  endtask

  // Called at posedge+1; checks combinational outputs mid-cycle, then the edge effects.
  task automatic run_cycle();
    int pcf, pcx, pred, tgt, corr, idx, tg;
    bit br, tk, res, fl, rst_low, hit;
    pcf = int'(bus.pc_IF);
    pcx = int'(bus.pc_EX);
    pred = int'(bus.branch_predicted_pc_EX);
    tgt = int'(bus.actual_target_EX);
    br = bus.is_branch_EX;
    tk = bus.actual_taken_EX;
    rst_low = !reset_n;
    res = bus.valid_EX && !bus.stall_EX && !rst_low;
    corr = (br && tk) ? tgt : (pcx + 1) % 65536;
    fl = res && (corr != pred);
    #4;
    check("pred_pc", bus.branch_predicted_pc_IF, m_pred(pcf));
    check("pred_taken", bus.predict_taken_IF, m_taken(pcf));
    check("correct_pc", bus.correct_pc, corr);
    check("flush", bus.mispredict_flush, fl);
    @(posedge clk);
    if (rst_low) m_reset();
    else if (res) begin
      if (fl && m_mcnt < 65535) m_mcnt++;
      if (br && m_bcnt < 65535) m_bcnt++;
      idx = pcx % 16;
      tg  = pcx / 16;
      hit = m_valid[idx] != 0 && m_tag[idx] == tg;
      if (br && tk) begin
        m_target[idx] = tgt;
        if (hit) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        else begin m_valid[idx] = 1; m_tag[idx] = tg; m_ctr[idx] = 2; end
      end else if (br) begin
        if (hit && m_ctr[idx] > 0) m_ctr[idx]--;
      end else if (hit) m_valid[idx] = 0;
    end
    #1;
    check("branch_count", bus.branch_count, m_bcnt);
    check("mispredict_count", bus.mispredict_count, m_mcnt);
  endtask

  function automatic int pick_pc();
    if ($urandom_range(7) == 0) return int'($urandom_range(65535));
    return int'($urandom_range(2)) * 16 + int'($urandom_range(3));
  endfunction

  int mc, r_pcx, r_pcf, r_pred, r_tgt;

  initial begin
    m_reset();
    reset_n   = 1'b0;
    bus.pc_IF = '0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    run_cycle();
    run_cycle();

    reset_n   = 1'b1;
    bus.pc_IF = 16'h0010;
    run_cycle();
    check("reset_taken", bus.predict_taken_IF, 0);
    check("reset_pred", bus.branch_predicted_pc_IF, 16'h0011);
    check("reset_bcnt", bus.branch_count, 0);
    check("reset_mcnt", bus.mispredict_count, 0);

    set_ex(1, 0, 1, 'h10, 'h11, 1, 'h40);
    run_cycle();
    check("cold_flush", bus.mispredict_flush, 1);
    check("cold_corr", bus.correct_pc, 16'h0040);
    check("cold_mcnt", bus.mispredict_count, 1);
    check("cold_next_pred", bus.branch_predicted_pc_IF, 16'h0040);
    check("cold_next_taken", bus.predict_taken_IF, 1);

    set_ex(1, 0, 1, 'h10, 'h40, 1, 'h40);
    run_cycle();
    check("hit_taken_flush", bus.mispredict_flush, 0);
    set_ex(1, 0, 1, 'h10, 'h40, 0, 'h40);
    run_cycle();
    check("nt1_flush", bus.mispredict_flush, 1);
    check("nt1_corr", bus.correct_pc, 16'h0011);
    check("nt1_still_taken", bus.branch_predicted_pc_IF, 16'h0040);
    run_cycle();
    check("nt2_pred", bus.branch_predicted_pc_IF, 16'h0011);
    check("nt2_taken", bus.predict_taken_IF, 0);

    set_ex(1, 0, 1, 'h10, 'h11, 1, 'h40);
    run_cycle();
    check("alias_setup", bus.branch_predicted_pc_IF, 16'h0040);
    set_ex(1, 0, 0, 'h10, 'h40, 0, 0);
    run_cycle();
    check("alias_flush", bus.mispredict_flush, 1);
    check("alias_corr", bus.correct_pc, 16'h0011);
    check("alias_pred", bus.branch_predicted_pc_IF, 16'h0011);

    set_ex(1, 0, 1, 'h10, 'h11, 1, 'h40);
    run_cycle();
    mc = m_mcnt;
    set_ex(1, 1, 1, 'h10, 'h40, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("stall_flush", bus.mispredict_flush, 0);
      check("stall_mcnt", bus.mispredict_count, mc);
    end
    bus.stall_EX = 1'b0;
    run_cycle();
    check("unstall_flush", bus.mispredict_flush, 1);
    check("unstall_mcnt", bus.mispredict_count, mc + 1);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check("bubble_flush", bus.mispredict_flush, 0);

    bus.pc_IF = 16'hFFFF;
    run_cycle();
    check("wrap_pred", bus.branch_predicted_pc_IF, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      r_pcx  = pick_pc();
      r_pcf  = ($urandom_range(3) == 0) ? r_pcx : pick_pc();
      r_pred = ($urandom_range(3) != 0) ? m_pred(r_pcx) : int'($urandom_range(65535));
      r_tgt  = int'($urandom_range(7)) * 16 + 'h100;
      set_ex($urandom_range(7) != 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
             r_pcx, r_pred, 1'($urandom_range(1)), r_tgt);
      bus.pc_IF = 16'(r_pcf);
      run_cycle();
    end

    set_ex(1, 0, 1, 'h20, 'h21, 1, 'h99);
    bus.pc_IF = 16'h0020;
    reset_n   = 1'b0;
    run_cycle();
    check("rst_mid_flush", bus.mispredict_flush, 0);
    reset_n = 1'b1;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    run_cycle();
    check("rst_mid_pred", bus.branch_predicted_pc_IF, 16'h0021);
    check("rst_mid_bcnt", bus.branch_count, 0);

    set_ex(1, 0, 1, 'h1234, 0, 0, 0);
    bus.pc_IF = 16'h1234;
    repeat (65535) @(posedge clk);
    m_bcnt = 65535;
    m_mcnt = 65535;
    #1;
    check("sat_mcnt_reach", bus.mispredict_count, 16'hFFFF);
    check("sat_bcnt_reach", bus.branch_count, 16'hFFFF);
    run_cycle();
    check("sat_mcnt_hold", bus.mispredict_count, 16'hFFFF);
    check("sat_bcnt_hold", bus.branch_count, 16'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
